eco32f_fetch: RTL and testbench

//  Instruction fetch stage: producer of id_pc/id_insn/id_exc_ibus_fault for the decode stage.

---
 rtl/eco32f_fetch.sv | 182 ++++++++++++++++++
 tb/tb_eco32f_fetch.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eco32f_fetch.sv
// Instruction fetch stage: single-outstanding ibus master feeding decode, with a 1-entry skid buffer.
// Build option: define ECO32F_FETCH_PREFETCH_EN to issue back-to-back requests (1 insn/cycle).
module eco32f_fetch #(
   parameter logic [31:0] RESET_PC = 32'hE000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] ibus_adr_o,
   output logic        ibus_req_o,
   input  logic [31:0] ibus_dat_i,
   input  logic        ibus_ack_i,
   input  logic        ibus_err_i,
   input  logic        id_stall,
   input  logic        id_bubble,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] id_pc,
   output logic [31:0] id_insn,
   output logic        id_exc_ibus_fault
);

   localparam logic [31:0] NOP = 32'h0000_0000;

   typedef enum logic [2:0] {
      S_REQ   = 3'd0,
      S_IDLE  = 3'd1,
      S_FULL  = 3'd2,
      S_FLUSH = 3'd3,
      S_FAULT = 3'd4
   } state_t;

`ifdef ECO32F_FETCH_PREFETCH_EN
   localparam state_t S_AFTER_ACK = S_REQ;
`else
   localparam state_t S_AFTER_ACK = S_IDLE;
`endif

   state_t      state_r, state_s;
   logic        req_r, req_s;
   logic [31:0] adr_r, adr_s;
   logic [31:0] flush_pc_r, flush_pc_s;
   logic [31:0] id_pc_r, id_pc_s;
   logic [31:0] id_insn_r, id_insn_s;
   logic        id_fault_r, id_fault_s;
   logic        skid_valid_r, skid_valid_s;
   logic [31:0] skid_insn_r, skid_insn_s;
   logic [31:0] skid_pc_r, skid_pc_s;
   logic        skid_fault_r, skid_fault_s;
   logic        hold_s, ack_s, err_s;
   logic        word_valid_s, word_fault_s;
   logic [31:0] word_insn_s, nop_pc_s, target_s;

   // Next-state, bus address, skid and decode-output selection
   always_comb begin
      hold_s       = id_stall | id_bubble;
      ack_s        = req_r & ibus_ack_i;
      err_s        = req_r & ibus_err_i;
      target_s     = redirect_pc_i & 32'hFFFF_FFFC;
      state_s      = state_r;
      adr_s        = adr_r;
      flush_pc_s   = flush_pc_r;
      word_valid_s = 1'b0;
      word_insn_s  = NOP;
      word_fault_s = 1'b0;
      nop_pc_s     = adr_r;
      skid_valid_s = skid_valid_r;
      skid_insn_s  = skid_insn_r;
      skid_pc_s    = skid_pc_r;
      skid_fault_s = skid_fault_r;
      id_pc_s      = id_pc_r;
      id_insn_s    = id_insn_r;
      id_fault_s   = id_fault_r;

      if (redirect_i) begin
         skid_valid_s = 1'b0;
         nop_pc_s     = target_s;
         flush_pc_s   = target_s;
         // The bus address must stay put until the outstanding transfer terminates
         if (req_r && !ack_s && !err_s) begin
            state_s = S_FLUSH;
         end else begin
            state_s = S_REQ;
            adr_s   = target_s;
         end
      end else begin
         case (state_r)
            S_REQ: begin
               if (ack_s) begin
                  adr_s        = adr_r + 32'd4;
                  word_valid_s = 1'b1;
                  word_insn_s  = ibus_dat_i;
                  if (hold_s) state_s = S_FULL;
                  else        state_s = S_AFTER_ACK;
               end else if (err_s) begin
                  word_valid_s = 1'b1;
                  word_fault_s = 1'b1;
                  state_s      = S_FAULT;
               end else begin
                  state_s = S_REQ;
               end
            end
            S_IDLE:  state_s = S_REQ;
            S_FULL: begin
               if (!hold_s) state_s = S_REQ;
               else         state_s = S_FULL;
            end
            S_FLUSH: begin
               nop_pc_s = flush_pc_r;
               if (ack_s || err_s) begin
                  state_s = S_REQ;
                  adr_s   = flush_pc_r;
               end else begin
                  state_s = S_FLUSH;
               end
            end
            S_FAULT: state_s = S_FAULT;
            default: state_s = S_REQ;
         endcase
      end

      if (!hold_s) begin
         if (skid_valid_r && !redirect_i) begin
            id_pc_s      = skid_pc_r;
            id_insn_s    = skid_insn_r;
            id_fault_s   = skid_fault_r;
            skid_valid_s = 1'b0;
         end else if (word_valid_s) begin
            id_pc_s    = adr_r;
            id_insn_s  = word_insn_s;
            id_fault_s = word_fault_s;
         end else begin
            id_pc_s    = nop_pc_s;
            id_insn_s  = NOP;
            id_fault_s = 1'b0;
         end
      end else begin
         // Decode is frozen: a word arriving now is parked in the skid
         skid_valid_s = skid_valid_s | word_valid_s;
         skid_insn_s  = word_valid_s ? word_insn_s  : skid_insn_s;
         skid_pc_s    = word_valid_s ? adr_r        : skid_pc_s;
         skid_fault_s = word_valid_s ? word_fault_s : skid_fault_s;
      end

      req_s = (state_s == S_REQ) || (state_s == S_FLUSH);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= S_REQ;
         req_r        <= 1'b0;
         adr_r        <= RESET_PC;
         flush_pc_r   <= RESET_PC;
         id_pc_r      <= RESET_PC;
         id_insn_r    <= NOP;
         id_fault_r   <= 1'b0;
         skid_valid_r <= 1'b0;
         skid_insn_r  <= NOP;
         skid_pc_r    <= RESET_PC;
         skid_fault_r <= 1'b0;
      end else begin
         state_r      <= state_s;
         req_r        <= req_s;
         adr_r        <= adr_s;
         flush_pc_r   <= flush_pc_s;
         id_pc_r      <= id_pc_s;
         id_insn_r    <= id_insn_s;
         id_fault_r   <= id_fault_s;
         skid_valid_r <= skid_valid_s;
         skid_insn_r  <= skid_insn_s;
         skid_pc_r    <= skid_pc_s;
         skid_fault_r <= skid_fault_s;
      end
   end

   assign ibus_adr_o        = adr_r;
   assign ibus_req_o        = req_r;
   assign id_pc             = id_pc_r;
   assign id_insn           = id_insn_r;
   assign id_exc_ibus_fault = id_fault_r;

endmodule

// File: tb/tb_eco32f_fetch.sv
// Self-checking bench for eco32f_fetch: randomized bus/pipeline stimulus against an in-order
// instruction-stream reference model, plus directed reset, stall, bubble, redirect and fault scenarios.
module tb_eco32f_fetch;

   localparam logic [31:0] RESET_PC = 32'hE000_0000;
   localparam logic [31:0] KEY      = 32'h1357_9BDF;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ibus_adr_o, ibus_dat_i, redirect_pc_i, id_pc, id_insn;
   logic        ibus_req_o, ibus_ack_i, ibus_err_i, id_stall, id_bubble, redirect_i, id_exc_ibus_fault;
   logic        dat_is_pc;

   always #5 clk = ~clk;

   assign ibus_dat_i = dat_is_pc ? ibus_adr_o : (ibus_adr_o ^ KEY);

   eco32f_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .ibus_adr_o(ibus_adr_o), .ibus_req_o(ibus_req_o), .ibus_dat_i(ibus_dat_i),
      .ibus_ack_i(ibus_ack_i), .ibus_err_i(ibus_err_i),
      .id_stall(id_stall), .id_bubble(id_bubble),
      .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .id_pc(id_pc), .id_insn(id_insn), .id_exc_ibus_fault(id_exc_ibus_fault)
   );

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
      logic        fault;
   } entry_t;

   // Reference model: the next in-order fetch pc, pending words not yet shown to decode,
   // and what decode is expected to see.
   entry_t      q[$];
   logic [31:0] m_pc, m_flush_adr, e_pc, e_insn;
   logic        m_flush, m_fault, e_fault;
   logic [31:0] dut_shown[$];

   function automatic logic [31:0] mem(input logic [31:0] a);
      return dat_is_pc ? a : (a ^ KEY);
   endfunction

   task automatic model_reset();
      q.delete();
      dut_shown.delete();
      m_pc = RESET_PC; m_flush = 1'b0; m_fault = 1'b0; m_flush_adr = RESET_PC;
      e_pc = RESET_PC; e_insn = 32'h0; e_fault = 1'b0;
   endtask

   task automatic drive_idle();
      ibus_ack_i = 1'b0; ibus_err_i = 1'b0; id_stall = 1'b0; id_bubble = 1'b0;
      redirect_i = 1'b0; redirect_pc_i = 32'h0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      drive_idle();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   // One clock: called just after a falling edge, returns just after the next falling edge.
   task automatic cycle(input logic a_ack, input logic a_err, input logic stall, input logic bubble,
                        input logic redir, input logic [31:0] rpc);
      logic req_b, ack_b, err_b, hold_b;
      logic [31:0] adr_b;
      entry_t ent;
      req_b = ibus_req_o;
      adr_b = ibus_adr_o;
      ibus_ack_i = a_ack & req_b;
      ibus_err_i = a_err & !a_ack & req_b;
      id_stall = stall; id_bubble = bubble; redirect_i = redir; redirect_pc_i = rpc;
      ack_b = ibus_ack_i; err_b = ibus_err_i; hold_b = stall | bubble;
      @(posedge clk);
      if (redir) begin
         q.delete();
         m_fault = 1'b0;
         m_pc = rpc & 32'hFFFF_FFFC;
         if (req_b && !ack_b && !err_b) begin
            m_flush = 1'b1;
            m_flush_adr = adr_b;
         end else begin
            m_flush = 1'b0;
         end
      end else if (m_flush) begin
         if (ack_b || err_b) m_flush = 1'b0;
      end else if (ack_b) begin
         q.push_back('{pc: m_pc, insn: mem(m_pc), fault: 1'b0});
         m_pc = m_pc + 32'd4;
      end else if (err_b) begin
         q.push_back('{pc: m_pc, insn: 32'h0, fault: 1'b1});
         m_fault = 1'b1;
      end
      if (!hold_b) begin
         if (q.size() > 0) begin
            ent = q.pop_front();
            e_pc = ent.pc; e_insn = ent.insn; e_fault = ent.fault;
         end else begin
            e_pc = m_pc; e_insn = 32'h0; e_fault = 1'b0;
         end
      end
      @(negedge clk);
      ibus_ack_i = 1'b0; ibus_err_i = 1'b0; redirect_i = 1'b0;
      checks++;
      if ({id_pc, id_insn, id_exc_ibus_fault} !== {e_pc, e_insn, e_fault}) begin
         errors++;
         $display("FAIL id_out: got pc=%h insn=%h fault=%b, want pc=%h insn=%h fault=%b",
                  id_pc, id_insn, id_exc_ibus_fault, e_pc, e_insn, e_fault);
      end
      if (m_fault) begin
         checks++;
         if (ibus_req_o !== 1'b0) begin
            errors++;
            $display("FAIL req_in_fault: got req=%b, want 0", ibus_req_o);
         end
      end else if (ibus_req_o === 1'b1) begin
         checks++;
         if (ibus_adr_o !== (m_flush ? m_flush_adr : m_pc)) begin
            errors++;
            $display("FAIL req_adr: got %h, want %h", ibus_adr_o, m_flush ? m_flush_adr : m_pc);
         end
      end
      if (!hold_b && id_insn !== 32'h0) dut_shown.push_back(id_pc);
   endtask

   task automatic wait_req();
      for (int i = 0; i < 8 && ibus_req_o !== 1'b1; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (ibus_req_o !== 1'b1) begin
         errors++;
         $display("FAIL wait_req: got req=%b, want 1 within 8 cycles", ibus_req_o);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   task automatic test_reset();
      check_val("reset_req", {31'h0, ibus_req_o}, 32'h0);
      check_val("reset_adr", ibus_adr_o, RESET_PC);
      check_val("reset_id_pc", id_pc, RESET_PC);
      check_val("reset_id_insn", id_insn, 32'h0);
      check_val("reset_fault", {31'h0, id_exc_ibus_fault}, 32'h0);
   endtask

   task automatic test_stream();
      apply_reset();
      dat_is_pc = 1'b1;
      for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_val("stream_w0", dut_shown.size() > 0 ? dut_shown[0] : 32'hX, 32'hE000_0000);
      check_val("stream_w1", dut_shown.size() > 1 ? dut_shown[1] : 32'hX, 32'hE000_0004);
      check_val("stream_w2", dut_shown.size() > 2 ? dut_shown[2] : 32'hX, 32'hE000_0008);
   endtask

   task automatic test_stall();
      apply_reset();
      dat_is_pc = 1'b1;
      wait_req();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
         check_val("stall_req_low", {31'h0, ibus_req_o}, 32'h0);
      end
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_val("stall_skid_pc", id_pc, 32'hE000_0000);
      check_val("stall_skid_insn", id_insn, 32'hE000_0000);
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_bubble();
      logic done;
      apply_reset();
      dat_is_pc = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 30 && !done; i++) begin
         if (id_pc === 32'hE000_0008 && id_insn === 32'hE000_0008) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
            check_val("bubble_pc", id_pc, 32'hE000_0008);
            check_val("bubble_insn", id_insn, 32'hE000_0008);
            done = 1'b1;
         end else begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
         end
      end
      check_val("bubble_reached", {31'h0, done}, 32'h1);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_redirect();
      apply_reset();
      dat_is_pc = 1'b1;
      wait_req();
      dut_shown.delete();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1000);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_val("redir_nop", id_insn, 32'h0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_val("redir_next_adr", ibus_adr_o, 32'h0000_1000);
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_val("redir_first_word", dut_shown.size() > 0 ? dut_shown[0] : 32'hX, 32'h0000_1000);
   endtask

   task automatic test_fault();
      logic hit;
      apply_reset();
      dat_is_pc = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         if (ibus_req_o === 1'b1 && ibus_adr_o === 32'hE000_0010) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            hit = 1'b1;
         end else begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
         end
      end
      check_val("fault_reached", {31'h0, hit}, 32'h1);
      check_val("fault_pc", id_pc, 32'hE000_0010);
      check_val("fault_insn", id_insn, 32'h0);
      check_val("fault_flag", {31'h0, id_exc_ibus_fault}, 32'h1);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_val("fault_req_idle", {31'h0, ibus_req_o}, 32'h0);
      dut_shown.delete();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hE000_0004);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_val("fault_resume", dut_shown.size() > 0 ? dut_shown[0] : 32'hX, 32'hE000_0004);
      check_val("fault_cleared", {31'h0, id_exc_ibus_fault}, 32'h0);
   endtask

   task automatic test_wrap();
      apply_reset();
      dat_is_pc = 1'b0;
      wait_req();
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFB);
      dut_shown.delete();
      for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_val("wrap_w0", dut_shown.size() > 0 ? dut_shown[0] : 32'hX, 32'hFFFF_FFF8);
      check_val("wrap_w2", dut_shown.size() > 2 ? dut_shown[2] : 32'hX, 32'h0000_0000);
   endtask

   task automatic test_random();
      apply_reset();
      dat_is_pc = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         cycle(($urandom % 3) != 0, ($urandom % 25) == 0, ($urandom % 5) == 0,
               ($urandom % 7) == 0, ($urandom % 20) == 0, $urandom);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      dat_is_pc = 1'b1;
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      wait_req();
      #2 rst = 1'b0;
      #1;
      test_reset();
      ibus_ack_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_val("rst_late_ack_insn", id_insn, 32'h0);
      check_val("rst_late_ack_req", {31'h0, ibus_req_o}, 32'h0);
      ibus_ack_i = 1'b0;
      rst = 1'b1;
      model_reset();
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_val("rst_restart", dut_shown.size() > 0 ? dut_shown[0] : 32'hX, RESET_PC);
   endtask

   initial begin
      rst = 1'b0;
      dat_is_pc = 1'b1;
      drive_idle();
      model_reset();
      repeat (2) @(negedge clk);
      test_reset();
      test_stream();
      test_stall();
      test_bubble();
      test_redirect();
      test_fault();
      test_wrap();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
